inst_loader: RTL and testbench

Program loader writing instruction memory, the write-side counterpart of the fetch stage's instruction memory read port. Accepts a byte stream carrying a word count and instruction payload, packs bytes into 32-bit words, and drives the instruction memory write port at word-aligned byte addresses. Holds the CPU (`cpu_hold`) for the whole load so fetch never reads a partially written program.

---
 rtl/inst_loader_pkg.sv | 29 ++
 rtl/inst_loader_packer.sv | 35 +++
 rtl/inst_loader.sv | 164 ++++++++++++++++
 tb/tb_inst_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction memory program loader: widths, stride,
// FSM state encoding and small state-decode helpers.
package inst_loader_pkg;

  localparam int INST_ADDR_W = 10;
  localparam int INST_W      = 32;
  localparam int WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  function automatic logic is_accepting(state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  // The CPU stays frozen during a load and after a failed one.
  function automatic logic holds_cpu(state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_WRITE) ||
           (s == ST_CSUM) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/inst_loader_packer.sv
// Little-endian byte-to-word packer: first pushed byte lands in [7:0].
// word_full/word describe the word completed by the byte pushed this cycle.
module inst_loader_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        data,
  output logic              word_full,
  output logic [INST_W-1:0] word
);

  logic [1:0]        idx_reg;
  logic [INST_W-1:0] shift_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (clear) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (push) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= {data, shift_reg[INST_W-1:8]};
    end
  end

  // Merged view including the incoming byte, so the top can register it on the fourth push.
  assign word_full = push && (idx_reg == 2'd3);
  assign word      = {data, shift_reg[INST_W-1:8]};

endmodule

// File: rtl/inst_loader.sv
// Program loader: byte stream (count header + payload) into instruction memory writes.
// Define INST_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] BASE_ADDR = 10'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wea,
  output logic [INST_ADDR_W-1:0] addra,
  output logic [INST_W-1:0]      dina,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  localparam logic [INST_ADDR_W-1:0] STRIDE = INST_ADDR_W'(WORD_STRIDE);

  state_t                 state_reg, state_next;
  logic [8:0]             words_left_reg;
  logic [INST_ADDR_W-1:0] addr_reg;
  logic [INST_W-1:0]      dina_reg;
  logic                   in_ready_reg, in_ready_next;
  logic                   wea_reg, wea_next;
  logic                   cpu_hold_reg, cpu_hold_next;
  logic                   done_reg, done_next;

  logic              accept, start_ok, last_word, push, word_full;
  logic [INST_W-1:0] word;

  assign accept    = in_valid && is_accepting(state_reg);
  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                               (state_reg == ST_ERR));
  assign last_word = (words_left_reg == 9'd1);
  assign push      = accept && (state_reg == ST_DATA);

  inst_loader_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .push      (push),
    .data      (in_data),
    .word_full (word_full),
    .word      (word)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       error_reg, error_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_reg <= '0;
    end else if (start_ok) begin
      csum_reg <= '0;
    end else if (accept && ((state_reg == ST_HDR) || (state_reg == ST_DATA))) begin
      csum_reg <= csum_reg ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_HDR;
      ST_HDR:           if (accept) state_next = ST_DATA;
      ST_DATA:          if (word_full) state_next = ST_WRITE;
      ST_WRITE: begin
        if (!last_word) state_next = ST_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
        else            state_next = ST_CSUM;
`else
        else            state_next = ST_DONE;
`endif
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) state_next = (in_data == csum_reg) ? ST_DONE : ST_ERR;
      ST_ERR:  if (start) state_next = ST_HDR;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the upcoming state so every port comes straight from a flop.
  always_comb begin
    in_ready_next = is_accepting(state_next);
    wea_next      = (state_next == ST_WRITE);
    cpu_hold_next = holds_cpu(state_next);
    done_next     = (state_next == ST_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
    error_next    = (state_next == ST_ERR);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_reg <= 1'b0;
      wea_reg      <= 1'b0;
      cpu_hold_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      error_reg    <= 1'b0;
`endif
    end else begin
      in_ready_reg <= in_ready_next;
      wea_reg      <= wea_next;
      cpu_hold_reg <= cpu_hold_next;
      done_reg     <= done_next;
`ifdef INST_LOADER_CHECKSUM_EN
      error_reg    <= error_next;
`endif
    end
  end

  // Header byte N means N+1 words, so the counter needs 9 bits to hold 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_left_reg <= '0;
      addr_reg       <= BASE_ADDR;
      dina_reg       <= '0;
    end else begin
      if (start_ok) begin
        words_left_reg <= '0;
        addr_reg       <= BASE_ADDR;
      end
      if ((state_reg == ST_HDR) && accept) begin
        words_left_reg <= {1'b0, in_data} + 9'd1;
      end
      if (state_reg == ST_WRITE) begin
        words_left_reg <= words_left_reg - 9'd1;
        addr_reg       <= addr_reg + STRIDE;
      end
      if (word_full) begin
        dina_reg <= word;
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign wea      = wea_reg;
  assign addra    = addr_reg;
  assign dina     = dina_reg;
  assign cpu_hold = cpu_hold_reg;
  assign done     = done_reg;
`ifdef INST_LOADER_CHECKSUM_EN
  assign error    = error_reg;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: two instances (base 0x000 and 0x3FC) share stimulus;
// a queue-based model of expected memory writes is checked by a write monitor.
module tb_inst_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;

  logic       in_ready0, wea0, cpu_hold0, done0, error0;
  logic [9:0] addra0;
  logic [31:0] dina0;
  logic       in_ready1, wea1, cpu_hold1, done1, error1;
  logic [9:0] addra1;
  logic [31:0] dina1;

  always #5 clk = ~clk;

  inst_loader #(.BASE_ADDR(10'h000)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .wea(wea0), .addra(addra0), .dina(dina0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0)
  );

  inst_loader #(.BASE_ADDR(10'h3FC)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .wea(wea1), .addra(addra1), .dina(dina1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] word;
  } wr_t;

  wr_t        exp0[$];
  wr_t        exp1[$];
  logic [7:0] payload[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Every write pulse must match the next expected write; stray pulses are errors.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (wea0) begin
      check("wea0_in_ready", {31'b0, in_ready0}, 32'd0);
      if (exp0.size() == 0) check("wea0_unexpected", {31'b0, wea0}, 32'd0);
      else begin
        e = exp0.pop_front();
        check("addra0", {22'b0, addra0}, {22'b0, e.addr});
        check("dina0", dina0, e.word);
      end
    end
    if (wea1) begin
      check("wea1_in_ready", {31'b0, in_ready1}, 32'd0);
      if (exp1.size() == 0) check("wea1_unexpected", {31'b0, wea1}, 32'd0);
      else begin
        e = exp1.pop_front();
        check("addra1", {22'b0, addra1}, {22'b0, e.addr});
        check("dina1", dina1, e.word);
      end
    end
  end

  initial begin
    #1ms;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values();
    check("rst_in_ready", {31'b0, in_ready0}, 32'd0);
    check("rst_wea", {31'b0, wea0}, 32'd0);
    check("rst_addra", {22'b0, addra0}, 32'h000);
    check("rst_dina", dina0, 32'd0);
    check("rst_cpu_hold", {31'b0, cpu_hold0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_error", {31'b0, error0}, 32'd0);
    check("rst_addra_wrap", {22'b0, addra1}, 32'h3FC);
    check("rst_cpu_hold_wrap", {31'b0, cpu_hold1}, 32'd0);
  endtask

  // Drives one byte and returns #1 after the edge that transfers it.
  task automatic send_byte(input logic [7:0] d, input bit gaps, input bit pulse_start);
    int t;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    if (pulse_start) start = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
      if (t > 50) begin
        check("accept_timeout", {31'b0, in_ready0}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
  endtask

  // n words from payload; reset_at >= 0 asserts reset before that payload byte.
  task automatic run_load(input int n, input bit gaps, input bit corrupt,
                          input bit mid_start, input int reset_at);
    logic [7:0]  csum;
    logic [31:0] w;
    int          k0;
    $display("load n=%0d gaps=%0d corrupt=%0d mid_start=%0d reset_at=%0d",
             n, gaps, corrupt, mid_start, reset_at);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    k0 = cyc;
    check("start_cpu_hold", {31'b0, cpu_hold0}, 32'd1);
    check("start_in_ready", {31'b0, in_ready0}, 32'd1);
    check("start_done_clr", {31'b0, done0}, 32'd0);
    check("start_error_clr", {31'b0, error0}, 32'd0);
    csum = 8'(n - 1);
    send_byte(8'(n - 1), gaps, 1'b0);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        w    = w | (32'(payload[4*i+b]) << (8 * b));
        csum = csum ^ payload[4*i+b];
      end
      exp0.push_back('{addr: 10'(4 * i), word: w});
      exp1.push_back('{addr: 10'(10'h3FC + 4 * i), word: w});
      for (int b = 0; b < 4; b++) begin
        if (reset_at == 4 * i + b) begin
          @(negedge clk);
          rst = 1'b0;
          @(posedge clk);
          #1;
          check_reset_values();
          exp0.delete();
          exp1.delete();
          in_valid = 1'b1;
          repeat (5) @(posedge clk);
          #1;
          check("rst_hold_in_ready", {31'b0, in_ready0}, 32'd0);
          in_valid = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          return;
        end
        send_byte(payload[4*i+b], gaps, mid_start && i == 0 && b == 1);
      end
      check("wea_latency", {31'b0, wea0}, 32'd1);
      check("wea_latency_wrap", {31'b0, wea1}, 32'd1);
      if (i == n - 1) check("done_not_early", {31'b0, done0}, 32'd0);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(corrupt ? (csum ^ 8'h5A) : csum, gaps, 1'b0);
`else
    @(posedge clk);
    #1;
`endif
    if (corrupt) begin
      check("err_error", {31'b0, error0}, 32'd1);
      check("err_done", {31'b0, done0}, 32'd0);
      check("err_cpu_hold", {31'b0, cpu_hold0}, 32'd1);
    end else begin
      check("done", {31'b0, done0}, 32'd1);
      check("done_cpu_hold", {31'b0, cpu_hold0}, 32'd0);
      check("done_error", {31'b0, error0}, 32'd0);
      check("done_wrap", {31'b0, done1}, 32'd1);
    end
    if (!gaps) begin
`ifdef INST_LOADER_CHECKSUM_EN
      check("load_cycles", 32'(cyc - k0), 32'(5 * n + 2));
`else
      check("load_cycles", 32'(cyc - k0), 32'(5 * n + 1));
`endif
    end
    check("pending_writes", 32'(exp0.size()), 32'd0);
    check("pending_writes_wrap", 32'(exp1.size()), 32'd0);
    // Stray bytes after the load must be ignored; the monitor flags any write.
    in_valid = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    check("idle_in_ready", {31'b0, in_ready0}, 32'd0);
    check("idle_cpu_hold", {31'b0, cpu_hold0}, {31'b0, corrupt});
  endtask

  initial begin
    int n;
    bit g, c;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;

    payload = '{8'h13, 8'h00, 8'hA0, 8'hE3};
    run_load(1, 1'b0, 1'b0, 1'b0, -1);
    check("directed_dina", dina0, 32'hE3A00013);

    fill_random(3);
    run_load(3, 1'b1, 1'b0, 1'b0, -1);
    fill_random(2);
    run_load(2, 1'b0, 1'b0, 1'b1, -1);
    fill_random(256);
    run_load(256, 1'b0, 1'b0, 1'b0, -1);
    fill_random(3);
    run_load(3, 1'b0, 1'b0, 1'b0, 6);
`ifdef INST_LOADER_CHECKSUM_EN
    fill_random(2);
    run_load(2, 1'b1, 1'b1, 1'b0, -1);
`endif
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      g = 1'($urandom_range(0, 1));
`ifdef INST_LOADER_CHECKSUM_EN
      c = ($urandom_range(0, 3) == 0);
`else
      c = 1'b0;
`endif
      fill_random(n);
      run_load(n, g, c, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
